// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch/data) arbiter onto a single SRAM-like bus, one transaction outstanding.
// Define MEM_ARB_RR_EN to alternate grants on simultaneous requests; otherwise data always wins.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_done,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_sel,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q;
    logic        bus_req_q;
    logic        owner_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        grant_data_d;
    logic        done_fire;

    function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
        case (sel)
            4'b1111:          sel_to_size = 2'd2;
            4'b0011, 4'b1100: sel_to_size = 2'd1;
            default:          sel_to_size = 2'd0;
        endcase
    endfunction

`ifdef MEM_ARB_RR_EN
    logic last_q;
    // On a tie, data wins only if fetch held the previous grant.
    assign grant_data_d = data_req & (~inst_req | ~last_q);
`else
    assign grant_data_d = data_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'b0000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
`ifdef MEM_ARB_RR_EN
            last_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (inst_req | data_req) begin
                        state_q   <= ADDR;
                        bus_req_q <= 1'b1;
                        owner_q   <= grant_data_d;
                        we_q      <= grant_data_d & data_we;
                        // Fetches are full words, so they carry an all-ones select.
                        sel_q     <= grant_data_d ? data_sel : 4'b1111;
                        addr_q    <= grant_data_d ? data_addr : inst_addr;
                        wdata_q   <= grant_data_d ? data_wdata : 32'h0;
`ifdef MEM_ARB_RR_EN
                        last_q    <= grant_data_d;
`endif
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) begin
                        state_q   <= DATA;
                        bus_req_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (bus_data_ok) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_wr    = we_q;
    assign bus_size  = sel_to_size(sel_q);
    assign bus_wstrb = we_q ? sel_q : 4'b0000;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    assign done_fire  = (state_q == DATA) & bus_data_ok;
    assign inst_done  = done_fire & ~owner_q;
    assign data_done  = done_fire & owner_q;
    assign inst_rdata = inst_done ? bus_rdata : 32'h0;
    assign data_rdata = data_done ? bus_rdata : 32'h0;

    assign stall_o = reset & ((inst_req & ~inst_done) | (data_req & ~data_done));

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- inst_req  in  1  fetch request; held high until inst_done.
- inst_addr  in  32  fetch byte address, word-aligned.
- inst_rdata  out  32  fetch read data, valid while inst_done=1.
- inst_done  out  1  one-cycle fetch completion strobe.
- data_req  in  1  MEM-stage request (ram_en); held high until data_done.
- data_we  in  1  1 = store, 0 = load.
- data_sel  in  4  byte strobes (0001/0011/1111 patterns, pre-shifted).
- data_addr  in  32  load/store byte address.
- data_wdata  in  32  store data (byte-replicated).
- data_rdata  out  32  load read data, valid while data_done=1.
- data_done  out  1  one-cycle data completion strobe.
- bus_req  out  1  SRAM-like bus request.
- bus_wr  out  1  bus write.
- bus_size  out  2  0 = byte, 1 = half, 2 = word.
- bus_wstrb  out  4  write byte strobes.
- bus_addr  out  32  bus address.
- bus_wdata  out  32  bus write data.
- bus_addr_ok  in  1  slave accepted the address phase.
- bus_data_ok  in  1  slave completed the data phase.
- bus_rdata  in  32  bus read data, valid with bus_data_ok.
- stall_o  out  1  pipeline stall request.

Function
REQ-002 FSM states SHALL be IDLE, ADDR, DATA; one transaction outstanding at a time.
REQ-003 In IDLE with any request high, the arbiter SHALL grant one requester, latch its addr/we/sel/wdata and owner ID into registers, and move to ADDR on the next edge.
REQ-004 Without MEM_ARB_RR_EN, simultaneous requests SHALL grant data.
REQ-005 In ADDR, bus_req SHALL be 1 and bus_addr/bus_wr/bus_size/bus_wstrb/bus_wdata SHALL be driven from the latched registers only; on bus_addr_ok the FSM SHALL move to DATA.
REQ-006 Fetch transactions SHALL use bus_wr=0, bus_size=2, bus_wstrb=0000.
REQ-007 Data transactions SHALL map sel to size: 0001 -> 0, 0011 or 1100 -> 1, 1111 -> 2, and any single-bit strobe -> 0. Loads SHALL drive bus_wstrb=0000; stores SHALL drive bus_wstrb=data_sel.
REQ-008 bus_data_ok SHALL be ignored outside DATA.
REQ-009 In DATA, bus_data_ok SHALL assert the owner's done combinationally in the same cycle, pass bus_rdata to the owner's rdata, and return the FSM to IDLE.
REQ-010 The non-owner's done SHALL stay 0.
REQ-011 Minimum latency SHALL be request seen at cycle T (IDLE), bus_req at T+1, done at T+2 when bus_addr_ok and bus_data_ok are immediate.
REQ-012 bus_req SHALL be 0 in IDLE and DATA.
REQ-013 stall_o SHALL equal (inst_req & ~inst_done) | (data_req & ~data_done).
REQ-014 A requester dropping req mid-transaction SHALL NOT abort it; the transaction SHALL complete and the done strobe SHALL still be issued.
REQ-015 Input changes after the grant SHALL NOT alter the bus signals of the transaction in flight.
REQ-016 When done fires, the next grant SHALL be evaluated in the following IDLE cycle, so each transaction occupies at least 3 cycles.

Reset
REQ-017 reset=0 SHALL immediately force IDLE and zero all latched registers and the last-grant register.
REQ-018 While reset=0, bus_req, inst_done, data_done and stall_o SHALL be 0.
REQ-019 While reset=0, bus_addr/bus_wdata/bus_rdata outputs SHALL read 32'h0, including when reset asserts mid-transaction.
REQ-020 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with reset=1.

Configuration
REQ-021 With macro MEM_ARB_RR_EN defined, a 1-bit last-grant register (reset value = inst) SHALL be kept, and simultaneous requests SHALL grant the requester not granted last.
REQ-022 With MEM_ARB_RR_EN undefined, the last-grant register SHALL be absent and fixed data priority (REQ-004) SHALL apply.

Verification
REQ-023 Single fetch inst_addr=32'hBFC00000, bus_addr_ok and bus_data_ok immediate, bus_rdata=32'h24010001 -> bus_req at T+1 with bus_size=2, inst_done at T+2, inst_rdata=32'h24010001.
REQ-024 Store byte data_addr=32'h80000003, data_sel=1000, data_wdata=32'hAAAAAAAA -> bus_wr=1, bus_size=0, bus_wstrb=1000, bus_addr=32'h80000003, data_done after bus_data_ok.
REQ-025 inst_req and data_req held together for 3 transactions -> without MEM_ARB_RR_EN: data, data, data (data_req re-raised each time); with MEM_ARB_RR_EN: data, inst, data.
REQ-026 Slave withholds bus_addr_ok 4 cycles; data_addr changes to 32'h0 during wait -> bus_req held and bus_addr stays at latched 32'h80001000.
REQ-027 reset=0 asserted in DATA state -> bus_req=0, done=0, stall_o=0 immediately; after release, a new request completes normally and a stale bus_data_ok in IDLE produces no done.
